// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, FSM encoding and index-width helper for the data memory
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_state_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mod_data_mem_param_if.sv
// rtl/mod_data_mem_param_if.sv - load/store port and second read port of the data memory
interface mod_data_mem_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   byte_en;
  logic [ADDR_W-1:0]     data_address_1;
  logic [DATA_W-1:0]     write_data;
  logic                  rd_req_2;
  logic [ADDR_W-1:0]     data_address_2;
  logic [DATA_W-1:0]     data_out_1;
  logic                  valid_1;
  logic [DATA_W-1:0]     data_out_2;
  logic                  valid_2;

  modport master (
    output mem_read, mem_write, byte_en, data_address_1, write_data, rd_req_2, data_address_2,
    input  data_out_1, valid_1, data_out_2, valid_2
  );

  modport slave (
    input  mem_read, mem_write, byte_en, data_address_1, write_data, rd_req_2, data_address_2,
    output data_out_1, valid_1, data_out_2, valid_2
  );
endinterface

// File: rtl/mod_mem_clr_seq.sv
// rtl/mod_mem_clr_seq.sv - clear sequencer: sweeps one word per cycle after reset or on request
module mod_mem_clr_seq
  import mips_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CLR_ON_RST = 1,
  localparam int IDX_W     = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);
  mem_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic             last;

  assign last = (ptr_q == IDX_W'(DEPTH - 1));

  // Pointer sits at 0 while idle so a new sweep always starts from word 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLR_ON_RST != 0) ? MEM_CLEAR : MEM_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MEM_IDLE || last) ptr_q <= '0;
      else                             ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE:  if (clr_req) state_d = MEM_CLEAR;
      MEM_CLEAR: if (last)    state_d = MEM_IDLE;
      default:                state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == MEM_CLEAR);
    clr_we   = busy;
    clr_addr = ptr_q;
  end
endmodule

// File: rtl/mod_data_mem_param.sv
// rtl/mod_data_mem_param.sv - byte-enabled data memory, registered read on two ports, sequenced clear
module mod_data_mem_param
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = 32,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_req,
  mod_data_mem_param_if.slave  bus,
  output logic                 busy,
  output logic                 addr_err
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic              in_1, in_2, wr_ok, rd1_ok, rd2_ok, err_d;
  logic [IDX_W-1:0]  idx_1, idx_2;

  mod_mem_clr_seq #(.DEPTH(DEPTH), .CLR_ON_RST(CLR_ON_RST)) u_clr_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Range check uses the full address so out-of-range values never alias after truncation
  assign in_1   = (bus.data_address_1 < ADDR_W'(DEPTH));
  assign in_2   = (bus.data_address_2 < ADDR_W'(DEPTH));
  assign idx_1  = bus.data_address_1[IDX_W-1:0];
  assign idx_2  = bus.data_address_2[IDX_W-1:0];
  assign wr_ok  = !busy && bus.mem_write && in_1;
  assign rd1_ok = !busy && bus.mem_read  && in_1;
  assign rd2_ok = !busy && bus.rd_req_2  && in_2;
  assign err_d  = !busy && ((((bus.mem_read || bus.mem_write) && !in_1)) || (bus.rd_req_2 && !in_2));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++)
        if (bus.byte_en[i]) mem[idx_1][8*i +: 8] <= bus.write_data[8*i +: 8];
    end
  end

  // Reads sample the array before this edge's write lands, giving read-first behaviour
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_out_1 <= '0;
      bus.data_out_2 <= '0;
      bus.valid_1    <= 1'b0;
      bus.valid_2    <= 1'b0;
      addr_err       <= 1'b0;
    end else begin
      bus.valid_1 <= rd1_ok;
      bus.valid_2 <= rd2_ok;
      addr_err    <= err_d;
      if (rd1_ok) bus.data_out_1 <= mem[idx_1];
      if (rd2_ok) bus.data_out_2 <= mem[idx_2];
    end
  end
endmodule

// File: tb/tb_mod_data_mem_param.sv
// tb/tb_mod_data_mem_param.sv - directed checks of the data memory at 64x32 and 48x64
module tb_mod_data_mem_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, clr_a, clr_b;
  logic busy_a, busy_b, err_a, err_b;

  mod_data_mem_param_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  mod_data_mem_param_if #(.DATA_W(64), .ADDR_W(32)) bus_b ();

  mod_data_mem_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .CLR_ON_RST(1)) dut_a (
    .clk(clk), .reset_n(rst_a), .clr_req(clr_a), .bus(bus_a.slave), .busy(busy_a), .addr_err(err_a)
  );
  mod_data_mem_param #(.DATA_W(64), .DEPTH(48), .ADDR_W(32), .CLR_ON_RST(1)) dut_b (
    .clk(clk), .reset_n(rst_b), .clr_req(clr_b), .bus(bus_b.slave), .busy(busy_b), .addr_err(err_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input logic mr, input logic mw, input logic [3:0] be, input logic [31:0] a1,
                      input logic [31:0] wd, input logic r2, input logic [31:0] a2);
    bus_a.mem_read = mr; bus_a.mem_write = mw; bus_a.byte_en = be;
    bus_a.data_address_1 = a1; bus_a.write_data = wd;
    bus_a.rd_req_2 = r2; bus_a.data_address_2 = a2;
    tick();
    bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.rd_req_2 = 1'b0;
  endtask

  task automatic op_b(input logic mr, input logic mw, input logic [7:0] be, input logic [31:0] a1,
                      input logic [63:0] wd, input logic r2, input logic [31:0] a2);
    bus_b.mem_read = mr; bus_b.mem_write = mw; bus_b.byte_en = be;
    bus_b.data_address_1 = a1; bus_b.write_data = wd;
    bus_b.rd_req_2 = r2; bus_b.data_address_2 = a2;
    tick();
    bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.rd_req_2 = 1'b0;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] exp, input string tag);
    op_a(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0, 32'h0);
    chk({tag, "_data"}, 64'(bus_a.data_out_1), 64'(exp));
    chk({tag, "_valid"}, 64'(bus_a.valid_1), 64'd1);
  endtask

  int   cnt;
  logic bad;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.byte_en = '0; bus_a.data_address_1 = '0;
    bus_a.write_data = '0; bus_a.rd_req_2 = 0; bus_a.data_address_2 = '0;
    bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.byte_en = '0; bus_b.data_address_1 = '0;
    bus_b.write_data = '0; bus_b.rd_req_2 = 0; bus_b.data_address_2 = '0;
    repeat (3) tick();

    chk("rst_data1", 64'(bus_a.data_out_1), 64'd0);
    chk("rst_valid1", 64'(bus_a.valid_1), 64'd0);
    chk("rst_valid2", 64'(bus_a.valid_2), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd1);

    // Power-on sweep lasts exactly DEPTH cycles
    rst_a = 1'b1;
    cnt = 0;
    while (busy_a && cnt < 200) begin tick(); cnt++; end
    chk("por_sweep_len", 64'(cnt), 64'd64);
    rd_a(32'd63, 32'h0, "t1_rd63");
    tick();
    chk("t1_valid_drop", 64'(bus_a.valid_1), 64'd0);

    // Byte-lane merge
    op_a(1'b0, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    op_a(1'b0, 1'b1, 4'b0010, 32'd5, 32'h00001200, 1'b0, 32'd0);
    rd_a(32'd5, 32'hDEAD12EF, "t2_merge");
    tick();
    chk("t2_hold_data", 64'(bus_a.data_out_1), 64'hDEAD12EF);
    op_a(1'b0, 1'b1, 4'h0, 32'd5, 32'h0, 1'b0, 32'd0);
    rd_a(32'd5, 32'hDEAD12EF, "be0_noop");

    // Read-first on both ports against a simultaneous write
    op_a(1'b0, 1'b1, 4'hF, 32'd9, 32'hAAAAAAAA, 1'b0, 32'd0);
    op_a(1'b1, 1'b1, 4'hF, 32'd9, 32'h11111111, 1'b1, 32'd9);
    chk("t3_rf_p1", 64'(bus_a.data_out_1), 64'hAAAAAAAA);
    chk("t3_rf_p2", 64'(bus_a.data_out_2), 64'hAAAAAAAA);
    chk("t3_v2", 64'(bus_a.valid_2), 64'd1);
    op_a(1'b1, 1'b0, 4'h0, 32'd9, 32'h0, 1'b1, 32'd9);
    chk("t3_new_p1", 64'(bus_a.data_out_1), 64'h11111111);
    chk("t3_new_p2", 64'(bus_a.data_out_2), 64'h11111111);

    // Out-of-range: no alias onto word 0, one error pulse for both ports
    op_a(1'b0, 1'b1, 4'hF, 32'd0, 32'h12345678, 1'b0, 32'd0);
    op_a(1'b0, 1'b1, 4'hF, 32'd64, 32'hCAFEF00D, 1'b1, 32'hFFFFFFFF);
    chk("t4_err", 64'(err_a), 64'd1);
    chk("t4_v2", 64'(bus_a.valid_2), 64'd0);
    tick();
    chk("t4_err_pulse", 64'(err_a), 64'd0);
    rd_a(32'd0, 32'h12345678, "t4_no_alias");
    op_a(1'b1, 1'b0, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'd0);
    chk("t4_rd_err", 64'(err_a), 64'd1);
    chk("t4_rd_v1", 64'(bus_a.valid_1), 64'd0);

    // Requested sweep; writes, reads, errors and a second clr_req are ignored while busy
    for (int i = 0; i < 64; i++) op_a(1'b0, 1'b1, 4'hF, i, 32'h100 + i, 1'b0, 32'd0);
    rd_a(32'd40, 32'h128, "t5_filled");
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    chk("t5_busy", 64'(busy_a), 64'd1);
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    tick();
    op_a(1'b1, 1'b1, 4'hF, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd100);
    chk("t5_busy_v1", 64'(bus_a.valid_1), 64'd0);
    chk("t5_busy_v2", 64'(bus_a.valid_2), 64'd0);
    chk("t5_busy_err", 64'(err_a), 64'd0);
    cnt = 3;
    while (busy_a && cnt < 200) begin tick(); cnt++; end
    chk("t5_sweep_len", 64'(cnt), 64'd64);
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      op_a(1'b1, 1'b0, 4'h0, i, 32'h0, 1'b0, 32'd0);
      if (bus_a.data_out_1 !== 32'h0 || bus_a.valid_1 !== 1'b1) bad = 1'b1;
    end
    chk("t5_all_zero", 64'(bad), 64'd0);

    // Reset mid-sweep aborts it; a full sweep restarts on release
    op_a(1'b0, 1'b1, 4'hF, 32'd7, 32'h55, 1'b0, 32'd0);
    op_a(1'b1, 1'b0, 4'h0, 32'd7, 32'h0, 1'b1, 32'd7);
    chk("t6_pre_read", 64'(bus_a.data_out_2), 64'h55);
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    repeat (30) tick();
    rst_a = 1'b0;
    #1;
    chk("t6_rst_d1", 64'(bus_a.data_out_1), 64'd0);
    chk("t6_rst_d2", 64'(bus_a.data_out_2), 64'd0);
    tick(); tick();
    bus_a.mem_read = 1'b1; bus_a.data_address_1 = 32'd7;
    bus_a.rd_req_2 = 1'b1; bus_a.data_address_2 = 32'd7;
    rst_a = 1'b1;
    cnt = 0; bad = 1'b0;
    while (busy_a && cnt < 200) begin
      tick(); cnt++;
      if (bus_a.valid_1 !== 1'b0 || bus_a.valid_2 !== 1'b0 || err_a !== 1'b0 ||
          bus_a.data_out_1 !== 32'h0 || bus_a.data_out_2 !== 32'h0) bad = 1'b1;
    end
    bus_a.mem_read = 1'b0; bus_a.rd_req_2 = 1'b0;
    chk("t6_sweep_len", 64'(cnt), 64'd64);
    chk("t6_quiet", 64'(bad), 64'd0);
    rd_a(32'd7, 32'h0, "t6_cleared");

    // Second configuration: 48 words of 64 bits
    rst_b = 1'b1;
    cnt = 0;
    while (busy_b && cnt < 200) begin tick(); cnt++; end
    chk("b_por_len", 64'(cnt), 64'd48);
    op_b(1'b0, 1'b1, 8'hFF, 32'd47, 64'h0123456789ABCDEF, 1'b0, 32'd0);
    op_b(1'b0, 1'b1, 8'h80, 32'd47, 64'hFF00000000000000, 1'b0, 32'd0);
    op_b(1'b1, 1'b0, 8'h00, 32'd47, 64'h0, 1'b1, 32'd47);
    chk("b_merge_p1", bus_b.data_out_1, 64'hFF23456789ABCDEF);
    chk("b_merge_p2", bus_b.data_out_2, 64'hFF23456789ABCDEF);
    op_b(1'b0, 1'b1, 8'hFF, 32'd48, 64'h1, 1'b0, 32'd0);
    chk("b_err48", 64'(err_b), 64'd1);
    op_b(1'b1, 1'b0, 8'h00, 32'd0, 64'h0, 1'b0, 32'd0);
    chk("b_no_alias", bus_b.data_out_1, 64'h0);
    op_b(1'b1, 1'b0, 8'h00, 32'd47, 64'h0, 1'b0, 32'd0);
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    repeat (30) tick();
    rst_b = 1'b0;
    #1;
    chk("b_rst_d1", bus_b.data_out_1, 64'h0);
    tick(); tick();
    bus_b.mem_read = 1'b1; bus_b.data_address_1 = 32'd47;
    rst_b = 1'b1;
    cnt = 0; bad = 1'b0;
    while (busy_b && cnt < 200) begin
      tick(); cnt++;
      if (bus_b.valid_1 !== 1'b0 || err_b !== 1'b0 || bus_b.data_out_1 !== 64'h0) bad = 1'b1;
    end
    bus_b.mem_read = 1'b0;
    chk("b_sweep_len", 64'(cnt), 64'd48);
    chk("b_quiet", 64'(bad), 64'd0);
    op_b(1'b1, 1'b0, 8'h00, 32'd47, 64'h0, 1'b0, 32'd0);
    chk("b_cleared", bus_b.data_out_1, 64'h0);
    chk("b_cleared_v", 64'(bus_b.valid_1), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
